// File: rtl/clock_ctrl_pkg.sv
// Shared types and helpers for the clock front-panel sequencer.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        CLOCK     = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        STOPWATCH = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        HOUR = 2'd0,
        MIN  = 2'd1,
        SEC  = 2'd2
    } field_t;

    localparam int SECS_PER_DAY = 86400;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            CLOCK:     return SET_TIME;
            SET_TIME:  return SET_ALARM;
            SET_ALARM: return STOPWATCH;
            default:   return CLOCK;
        endcase
    endfunction

    function automatic field_t next_field(input field_t f);
        case (f)
            HOUR:    return MIN;
            MIN:     return SEC;
            default: return HOUR;
        endcase
    endfunction

    function automatic logic is_set_mode(input mode_t m);
        return (m == SET_TIME) || (m == SET_ALARM);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, stability counter,
// one-cycle press pulse on the accepted 1->0 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          armed;
    logic          pending;
    logic [CW-1:0] cnt;

    // After reset no press is reported until a stable released level has been
    // seen, so a key held through reset stays silent until it is let go.
    assign pending = (sync2 != level) || (!armed && sync2);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (!pending) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                armed <= armed | sync2;
                press <= armed & level & ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_mode_controller.sv
// Front-panel sequencer: key debounce, mode FSM, 1 Hz tick/blink generation and
// datapath strobes. Optional auto-repeat of the inc key: CLOCK_MODE_AUTOREPEAT_EN.
module clock_mode_controller
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_HZ       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode_n,
    input  logic       key_sel_n,
    input  logic       key_inc_n,
    output logic [1:0] mode,
    output logic [1:0] field,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_sec,
    output logic       inc_target,
    output logic       time_tick,
    output logic       sw_tick,
    output logic       sw_clear,
    output logic       sw_running,
    output logic       blink
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PCNT_HALF = PW'(CLK_HZ / 2);

    logic [PW-1:0] pcnt;
    logic          tick1;
    logic          half;

    assign tick1 = (pcnt == PCNT_LAST);
    assign half  = (pcnt >= PCNT_HALF);

    always_ff @(posedge clk) begin
        if (rst || tick1) pcnt <= '0;
        else              pcnt <= pcnt + 1'b1;
    end

    logic p_mode, p_sel, p_inc;
    logic unused_mode_level, unused_sel_level, inc_level;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
        .clk(clk), .rst(rst), .key_n(key_mode_n), .level(unused_mode_level), .press(p_mode)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
        .clk(clk), .rst(rst), .key_n(key_sel_n), .level(unused_sel_level), .press(p_sel)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk(clk), .rst(rst), .key_n(key_inc_n), .level(inc_level), .press(p_inc)
    );

    mode_t  mode_q, mode_d;
    field_t field_q, field_d;
    logic   sw_run_q, sw_run_d;
    logic   rep_pulse;
    logic   inc_fire;

`ifdef CLOCK_MODE_AUTOREPEAT_EN
    localparam int HOLD_CYCLES = CLK_HZ;
    localparam int RPT_CYCLES  = (CLK_HZ / REPEAT_HZ > 0) ? CLK_HZ / REPEAT_HZ : 1;
    localparam int RW          = $clog2(HOLD_CYCLES + 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_armed;
    logic          rep_hold;

    // First repeat after one second of hold, then one every RPT_CYCLES.
    assign rep_hold  = !inc_level && is_set_mode(mode_q);
    assign rep_pulse = rep_hold && !p_inc &&
                       ((!rep_armed && rep_cnt == RW'(HOLD_CYCLES - 1)) ||
                        ( rep_armed && rep_cnt == RW'(RPT_CYCLES - 1)));

    always_ff @(posedge clk) begin
        if (rst || p_mode || p_inc || !rep_hold) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (rep_pulse) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    logic        unused_inc_level;
    logic [31:0] unused_repeat_hz;

    assign rep_pulse        = 1'b0;
    assign unused_inc_level = inc_level;
    assign unused_repeat_hz = 32'(REPEAT_HZ);
`endif

    assign inc_fire = p_inc | rep_pulse;

    logic inc_hour_d, inc_min_d, inc_sec_d, inc_target_d;
    logic time_tick_d, sw_tick_d, sw_clear_d, blink_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= CLOCK;
            field_q    <= HOUR;
            sw_run_q   <= 1'b0;
            inc_hour   <= 1'b0;
            inc_min    <= 1'b0;
            inc_sec    <= 1'b0;
            inc_target <= 1'b0;
            time_tick  <= 1'b0;
            sw_tick    <= 1'b0;
            sw_clear   <= 1'b0;
            blink      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            field_q    <= field_d;
            sw_run_q   <= sw_run_d;
            inc_hour   <= inc_hour_d;
            inc_min    <= inc_min_d;
            inc_sec    <= inc_sec_d;
            inc_target <= inc_target_d;
            time_tick  <= time_tick_d;
            sw_tick    <= sw_tick_d;
            sw_clear   <= sw_clear_d;
            blink      <= blink_d;
        end
    end

    // A mode press wins: same-cycle sel/inc presses are dropped.
    always_comb begin
        mode_d   = mode_q;
        field_d  = field_q;
        sw_run_d = sw_run_q;
        if (p_mode) begin
            mode_d  = next_mode(mode_q);
            field_d = HOUR;
        end else begin
            case (mode_q)
                SET_TIME, SET_ALARM: if (p_sel) field_d = next_field(field_q);
                STOPWATCH:           if (p_sel) sw_run_d = !sw_run_q;
                default: ;
            endcase
        end
    end

    // Strobes are valid-only single-cycle pulses; the datapath has no ready and
    // must act on each one in the cycle it is high.
    always_comb begin
        inc_hour_d = 1'b0;
        inc_min_d  = 1'b0;
        inc_sec_d  = 1'b0;
        if (!p_mode && is_set_mode(mode_q) && inc_fire) begin
            case (field_q)
                HOUR:    inc_hour_d = 1'b1;
                MIN:     inc_min_d  = 1'b1;
                SEC:     inc_sec_d  = 1'b1;
                default: ;
            endcase
        end
        sw_clear_d   = !p_mode && (mode_q == STOPWATCH) && p_inc && !sw_run_q;
        inc_target_d = (mode_d == SET_ALARM);
        blink_d      = half && is_set_mode(mode_d);
        time_tick_d  = tick1 && (mode_d != SET_TIME);
        sw_tick_d    = tick1 && sw_run_q;
    end

    assign mode       = mode_q;
    assign field      = field_q;
    assign sw_running = sw_run_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller with CLK_HZ=8, DEBOUNCE_CYCLES=3;
// strobes are checked through an expected-event queue, levels in idle windows.
module tb_clock_mode_controller;

    localparam int CLK_HZ = 8;
    localparam int DEB    = 3;
    localparam int LAT    = 2 + DEB + 1;
    localparam int K_MODE = 0;
    localparam int K_SEL  = 1;
    localparam int K_INC  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode_n = 1'b1;
    logic       key_sel_n  = 1'b1;
    logic       key_inc_n  = 1'b1;
    logic [1:0] mode, field;
    logic       inc_hour, inc_min, inc_sec, inc_target;
    logic       time_tick, sw_tick, sw_clear, sw_running, blink;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [4:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [4:0] mon_ev;
    int         mon_ec;

    clock_mode_controller #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .REPEAT_HZ(4)
    ) dut (
        .clk(clk), .rst(rst),
        .key_mode_n(key_mode_n), .key_sel_n(key_sel_n), .key_inc_n(key_inc_n),
        .mode(mode), .field(field),
        .inc_hour(inc_hour), .inc_min(inc_min), .inc_sec(inc_sec), .inc_target(inc_target),
        .time_tick(time_tick), .sw_tick(sw_tick), .sw_clear(sw_clear),
        .sw_running(sw_running), .blink(blink)
    );

    // clock / reset-relative cycle count (edges since reset released)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor: every strobe the DUT presents consumes one expected event
    always @(negedge clk) begin
        if (!rst && (inc_hour || inc_min || inc_sec || sw_clear)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %b at cycle %0d required none",
                         {inc_target, inc_hour, inc_min, inc_sec, sw_clear}, cyc);
            end else begin
                mon_ev = exp_q.pop_front();
                mon_ec = exp_cyc_q.pop_front();
                check("strobe_vec", {27'd0, inc_target, inc_hour, inc_min, inc_sec, sw_clear},
                      {27'd0, mon_ev});
                check("strobe_cycle", cyc, mon_ec);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            K_MODE:  key_mode_n = v;
            K_SEL:   key_sel_n  = v;
            default: key_inc_n  = v;
        endcase
    endtask

    task automatic expect_strobe(input logic [4:0] v, input int at);
        exp_q.push_back(v);
        exp_cyc_q.push_back(at);
    endtask

    task automatic press(input int k, input logic [4:0] v, input bit want);
        if (want) expect_strobe(v, cyc + LAT);
        set_key(k, 1'b0);
        repeat (6) step();
        set_key(k, 1'b1);
        repeat (8) step();
    endtask

    task automatic press_pair(input int k0, input int k1);
        set_key(k0, 1'b0);
        set_key(k1, 1'b0);
        repeat (6) step();
        set_key(k0, 1'b1);
        set_key(k1, 1'b1);
        repeat (8) step();
    endtask

    task automatic glitch_inc(input int len);
        key_inc_n = 1'b0;
        repeat (len) step();
        key_inc_n = 1'b1;
        repeat (8) step();
    endtask

    task automatic bounce_inc(input logic [4:0] v);
        for (int i = 0; i < 6; i++) begin
            key_inc_n = (i % 2 == 1);
            step();
        end
        expect_strobe(v, cyc + LAT);
        key_inc_n = 1'b0;
        repeat (6) step();
        key_inc_n = 1'b1;
        repeat (8) step();
    endtask

    task automatic idle_check(input int n, input bit tick_ok, input bit blink_on, input bit sw_on);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("time_tick", time_tick, tick_ok && (cyc % CLK_HZ == 0));
            check("blink", blink, blink_on && (((cyc + CLK_HZ - 1) % CLK_HZ) >= CLK_HZ / 2));
            check("sw_tick", sw_tick, sw_on && (cyc % CLK_HZ == 0));
        end
        step();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_field"}, field, 0);
        check({tag, "_inc_hour"}, inc_hour, 0);
        check({tag, "_inc_min"}, inc_min, 0);
        check({tag, "_inc_sec"}, inc_sec, 0);
        check({tag, "_inc_target"}, inc_target, 0);
        check({tag, "_time_tick"}, time_tick, 0);
        check({tag, "_sw_tick"}, sw_tick, 0);
        check({tag, "_sw_clear"}, sw_clear, 0);
        check({tag, "_sw_running"}, sw_running, 0);
        check({tag, "_blink"}, blink, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check_reset("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) step();

        // mode rotation, field returns to HOUR on each set-mode entry
        press(K_MODE, '0, 0);
        check("mode_set_time", mode, 1);
        check("field_entry_time", field, 0);
        check("target_time", inc_target, 0);
        press(K_SEL, '0, 0);
        check("field_min", field, 1);
        press(K_MODE, '0, 0);
        check("mode_set_alarm", mode, 2);
        check("field_entry_alarm", field, 0);
        check("target_alarm", inc_target, 1);
        press(K_MODE, '0, 0);
        check("mode_stopwatch", mode, 3);
        press(K_MODE, '0, 0);
        check("mode_clock", mode, 0);
        idle_check(16, 1, 0, 0);

        // SET_TIME: clock frozen, blink on, inc goes to hour of time register
        press(K_MODE, '0, 0);
        check("mode_set_time2", mode, 1);
        idle_check(16, 0, 1, 0);
        press(K_INC, 5'b01000, 1);

        // SET_ALARM: minutes field, glitch rejected, bounce gives one strobe
        press(K_MODE, '0, 0);
        check("mode_set_alarm2", mode, 2);
        check("field_entry_alarm2", field, 0);
        press(K_SEL, '0, 0);
        check("field_min2", field, 1);
        glitch_inc(2);
        glitch_inc(1);
        bounce_inc(5'b10100);
        press(K_INC, 5'b10100, 1);
        check("target_alarm2", inc_target, 1);
        idle_check(16, 1, 1, 0);

        // STOPWATCH: start/stop, clear only while stopped, runs in background
        press(K_MODE, '0, 0);
        check("mode_stopwatch2", mode, 3);
        press(K_SEL, '0, 0);
        check("sw_started", sw_running, 1);
        idle_check(16, 1, 0, 1);
        press(K_INC, '0, 0);
        press(K_SEL, '0, 0);
        check("sw_stopped", sw_running, 0);
        press(K_INC, 5'b00001, 1);
        press(K_SEL, '0, 0);
        check("sw_restarted", sw_running, 1);
        press(K_MODE, '0, 0);
        check("mode_clock2", mode, 0);
        check("sw_bg_running", sw_running, 1);
        idle_check(16, 1, 0, 1);

        // mode press and inc press in the same cycle: mode wins, no strobe
        press(K_MODE, '0, 0);
        check("mode_set_time3", mode, 1);
        press_pair(K_MODE, K_INC);
        check("prio_mode", mode, 2);
        check("prio_field", field, 0);

        // reset mid-debounce with keys held
        key_mode_n = 1'b0;
        key_inc_n  = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check_reset("mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) step();
        check("held_mode", mode, 0);
        check("held_sw_running", sw_running, 0);
        key_mode_n = 1'b1;
        key_inc_n  = 1'b1;
        repeat (10) step();
        press(K_MODE, '0, 0);
        check("post_rst_mode", mode, 1);
        press(K_INC, 5'b01000, 1);

        repeat (4) step();
        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
- Front-panel sequencer for the board's digital clock datapath (timekeeper, alarm register, stopwatch counter, 7-seg driver).
- Functions:
  - Debounces the three push-buttons.
  - Runs the mode FSM: CLOCK, SET_TIME, SET_ALARM, STOPWATCH.
  - Generates 1 Hz tick enables and the blink phase.
  - Issues single-cycle increment/control strobes to the datapath.
- The datapath never sees raw keys or derived clocks. Everything stays in the `clk` domain.

Parameters:
- CLK_HZ, 50000000: input clock frequency; tick prescaler modulus.
- DEBOUNCE_CYCLES, 1000000: cycles a key level must stay stable before it is accepted (20 ms at 50 MHz).
- REPEAT_HZ, 4: auto-repeat rate (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- key_mode_n  in  1  raw button, active-low; cycles the mode.
- key_sel_n  in  1  raw button, active-low; selects the field, or start/stop in STOPWATCH.
- key_inc_n  in  1  raw button, active-low; increments the field, or clears in STOPWATCH.
- mode  out  2  0=CLOCK, 1=SET_TIME, 2=SET_ALARM, 3=STOPWATCH.
- field  out  2  0=HOUR, 1=MIN, 2=SEC; valid only in the set modes.
- inc_hour, inc_min, inc_sec  out  1 each  one-cycle increment strobes.
- inc_target  out  1  0=time register, 1=alarm register; qualifies the inc_* strobes.
- time_tick  out  1  one-cycle 1 Hz enable for the timekeeper.
- sw_tick  out  1  one-cycle 1 Hz enable for the stopwatch counter.
- sw_clear  out  1  one-cycle stopwatch clear.
- sw_running  out  1  stopwatch run state.
- blink  out  1  1 = blank the selected field.

Behaviour:
- Prescaler:
  - pcnt counts 0..CLK_HZ-1 and wraps.
  - tick1 = (pcnt==CLK_HZ-1), a one-cycle pulse.
  - half = (pcnt >= CLK_HZ/2).
- blink = half & (mode==SET_TIME | mode==SET_ALARM). Otherwise 0.
- time_tick = tick1 & (mode != SET_TIME). The clock freezes only while its own time is being set.
- sw_tick = tick1 & sw_running. The stopwatch runs in the background in every mode.
- Debounce, per key:
  - 2-flop synchroniser, then a stable counter.
  - The accepted level updates after DEBOUNCE_CYCLES consecutive equal samples.
  - A press is the accepted 1->0 transition. It gives one-cycle pulses p_mode, p_sel, p_inc.
  - Release produces nothing.
- Mode FSM:
  - p_mode: CLOCK->SET_TIME->SET_ALARM->STOPWATCH->CLOCK.
  - Entering SET_TIME or SET_ALARM sets field=HOUR.
- In SET_TIME / SET_ALARM:
  - p_sel rotates HOUR->MIN->SEC->HOUR.
  - p_inc asserts exactly one of inc_hour/inc_min/inc_sec per field, in the next cycle.
  - inc_target = (mode==SET_ALARM), held stable.
  - Wrap of the register value (23->0, 59->0) is the datapath's job.
- In STOPWATCH:
  - p_sel toggles sw_running.
  - p_inc while stopped: sw_clear pulses for one cycle.
  - p_inc while running: ignored.
- In CLOCK: p_sel and p_inc are ignored.
- Simultaneous events:
  - p_mode has priority. Any p_sel/p_inc in the same cycle is dropped.
  - tick1 and an inc strobe in the same cycle are both emitted; the datapath applies tick first, then inc.
- Latency: raw edge to strobe = 2 sync + DEBOUNCE_CYCLES + 1 registered output.
- All outputs are registered.
- Reset (any time, including mid-press or mid-debounce):
  - mode=CLOCK, field=HOUR.
  - All strobes 0, sw_running=0, blink=0, inc_target=0.
  - pcnt=0 and debounce counters 0.
  - Accepted key levels reset to 1 (released), so a key held through reset produces no press.

Optional Feature:
- Macro: CLOCK_MODE_AUTOREPEAT_EN.
- Defined:
  - In the set modes, key_inc held (accepted level 0) for 1 s after its press pulse produces further inc strobes every CLK_HZ/REPEAT_HZ cycles until release.
  - The repeat counter resets on release, on a mode change, and on rst.
- Undefined: one strobe per press only; no repeat counter is synthesised.

Decomposition:
- Package clock_ctrl_pkg holds:
  - enum mode_t {CLOCK, SET_TIME, SET_ALARM, STOPWATCH}.
  - enum field_t {HOUR, MIN, SEC}.
  - localparam SECS_PER_DAY=86400.
- Sub-module key_debounce (param DEBOUNCE_CYCLES; ports clk, rst, key_n, level, press), instantiated three times.

Test Plan (CLK_HZ=8, DEBOUNCE_CYCLES=3):
- Key bounce: key_inc_n toggles 0/1 every cycle for 6 cycles, then holds 0 -> exactly one p_inc, 2+3+1 cycles after the final stable edge. Glitches shorter than 3 cycles -> no pulse.
- Mode cycle: 4 p_mode presses -> mode 1,2,3,0. Field reads HOUR on each entry to the set modes.
- SET_ALARM: p_sel once, then p_inc twice -> inc_min pulses twice, inc_target=1, no inc_hour/inc_sec. time_tick keeps pulsing every 8 cycles. blink is high for pcnt 4..7.
- SET_TIME: time_tick stays 0 for 16 cycles. Return to CLOCK -> time_tick resumes on the next pcnt==7.
- STOPWATCH:
  - p_sel -> sw_running=1, sw_tick every 8 cycles, continuing after p_mode to CLOCK.
  - p_inc while running -> no sw_clear.
  - Stop, then p_inc -> one sw_clear.
- Reset / priority:
  - rst asserted mid-debounce in SET_ALARM with key held -> all outputs at reset values next cycle; no press after rst deasserts while the key stays held.
  - p_mode and p_inc in the same cycle -> mode advances, no inc strobe.
